// File: rtl/my_ip_pkg.sv
// Shared types, frame constants and small helpers for the UDP/IPv4 MII transmitter.
package my_ip_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheckSum,
    StPreamble,
    StEthHead,
    StIpUdpHead,
    StSendData,
    StSendCrc
  } state_e;

  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam int unsigned MIN_PAYLOAD  = 18;
  localparam logic [7:0]  PREAMBLE     = 8'h55;
  localparam logic [7:0]  SFD          = 8'hD5;

  // Fold a 32-bit ones-complement accumulator down to 16 bits.
  function automatic logic [15:0] csum_fold(input logic [31:0] sum);
    logic [16:0] s1;
    s1 = {1'b0, sum[31:16]} + {1'b0, sum[15:0]};
    return s1[15:0] + {15'd0, s1[16]};
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

endpackage

// File: rtl/ip_checksum.sv
// Two-stage pipelined IPv4 header checksum; settles two cycles after its inputs.
module ip_checksum
  import my_ip_pkg::*;
#(
  parameter logic [31:0] SRC_IP = 32'h0,
  parameter logic [31:0] DST_IP = 32'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] total_len,
  input  logic [15:0] ip_id,
  output logic [15:0] checksum
);

  logic [31:0] sum_d, sum_q;

  // Checksum field itself is summed as zero.
  always_comb begin
    sum_d = 32'(16'h4500) + 32'(total_len) + 32'(ip_id) + 32'(16'h4000)
          + 32'({8'h40, IP_PROTO_UDP})
          + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
          + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sum_q    <= '0;
      checksum <= '0;
    end else begin
      sum_q    <= sum_d;
      checksum <= ~csum_fold(sum_q);
    end
  end

endmodule

// File: rtl/my_ip_send.sv
// MII (4-bit) transmitter for a fixed-address UDP/IPv4 Ethernet frame; FCS comes
// from an external nibble-wide CRC32 block.
module my_ip_send
  import my_ip_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC  = 48'h12_34_56_78_9A_BC,
  parameter logic [31:0] BOARD_IP   = {8'd169, 8'd254, 8'd1, 8'd23},
  parameter logic [47:0] DES_MAC    = 48'h1C_2B_3A_49_58_67,
  parameter logic [31:0] DES_IP     = {8'd169, 8'd254, 8'd191, 8'd31},
  parameter logic [15:0] BOARD_PORT = 16'd1234,
  parameter logic [15:0] DES_PORT   = 16'd1234
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        send_en,
  input  logic [31:0] send_data,
  input  logic [15:0] send_data_num,
  input  logic [31:0] crc_data,
  input  logic [3:0]  crc_next,
  output logic        send_end,
  output logic        read_data_req,
  output logic        eth_tx_en,
  output logic [3:0]  eth_tx_data,
  output logic        crc_en,
  output logic        crc_clr
);

  localparam int unsigned CntW = 17;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [15:0]      num_q, id_q, checksum;
  logic [15:0]      byte_idx, total_len, udp_len;
  logic [CntW-1:0]  data_nibs;
  logic [13:0][7:0] eth_hdr;
  logic [27:0][7:0] ipudp_hdr;
  logic [7:0][3:0]  crc_nibs;
  logic [7:0]       cur_byte;
  logic [3:0]       data_nib, fcs_nib;
  logic             more_words;

  // cnt_q counts nibbles within the current state; bit 0 picks low/high nibble.
  assign byte_idx  = cnt_q[CntW-1:1];
  assign total_len = num_q + 16'd28;
  assign udp_len   = num_q + 16'd8;
  assign data_nibs = (num_q < 16'(MIN_PAYLOAD)) ? CntW'(2 * MIN_PAYLOAD) : {num_q, 1'b0};

  assign eth_hdr   = {DES_MAC, BOARD_MAC, ETH_TYPE_IP};
  assign ipudp_hdr = {16'h4500, total_len, id_q, 16'h4000, 8'h40, IP_PROTO_UDP, checksum,
                      BOARD_IP, DES_IP, BOARD_PORT, DES_PORT, udp_len, 16'h0000};
  assign crc_nibs  = crc_data;

  assign more_words = (CntW'(byte_idx) + CntW'(1)) < {1'b0, num_q};

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      StPreamble:  cur_byte = (byte_idx == 16'd7) ? SFD : PREAMBLE;
      StEthHead:   cur_byte = eth_hdr[4'd13 - byte_idx[3:0]];
      StIpUdpHead: cur_byte = ipudp_hdr[5'd27 - byte_idx[4:0]];
      StSendData: begin
        if (byte_idx < num_q) begin
          case (byte_idx[1:0])
            2'd0:    cur_byte = send_data[31:24];
            2'd1:    cur_byte = send_data[23:16];
            2'd2:    cur_byte = send_data[15:8];
            default: cur_byte = send_data[7:0];
          endcase
        end
      end
      default:     cur_byte = 8'h00;
    endcase
  end

  assign data_nib = cnt_q[0] ? cur_byte[7:4] : cur_byte[3:0];
  // First FCS nibble must include the data nibble still on the wire.
  assign fcs_nib  = (cnt_q[2:0] == 3'd0) ? ~rev4(crc_next) : ~rev4(crc_nibs[3'd7 - cnt_q[2:0]]);

  ip_checksum #(
    .SRC_IP(BOARD_IP),
    .DST_IP(DES_IP)
  ) u_ip_checksum (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .total_len(total_len),
    .ip_id    (id_q),
    .checksum (checksum)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      num_q         <= '0;
      id_q          <= '0;
      send_end      <= 1'b0;
      read_data_req <= 1'b0;
      eth_tx_en     <= 1'b0;
      eth_tx_data   <= '0;
      crc_en        <= 1'b0;
      crc_clr       <= 1'b0;
    end else begin
      send_end      <= 1'b0;
      read_data_req <= 1'b0;
      crc_clr       <= 1'b0;
      case (state_q)
        StIdle: begin
          eth_tx_en   <= 1'b0;
          eth_tx_data <= '0;
          crc_en      <= 1'b0;
          cnt_q       <= '0;
          if (send_en) begin
            num_q   <= send_data_num;
            state_q <= StCheckSum;
          end
        end
        StCheckSum: begin
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(3)) begin
            cnt_q   <= '0;
            state_q <= StPreamble;
          end
        end
        StPreamble: begin
          eth_tx_en   <= 1'b1;
          eth_tx_data <= data_nib;
          crc_en      <= 1'b0;
          cnt_q       <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(15)) begin
            cnt_q   <= '0;
            state_q <= StEthHead;
          end
        end
        StEthHead: begin
          eth_tx_en   <= 1'b1;
          eth_tx_data <= data_nib;
          crc_en      <= 1'b1;
          cnt_q       <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(27)) begin
            cnt_q   <= '0;
            state_q <= StIpUdpHead;
          end
        end
        StIpUdpHead: begin
          eth_tx_en   <= 1'b1;
          eth_tx_data <= data_nib;
          crc_en      <= 1'b1;
          cnt_q       <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(55)) begin
            cnt_q         <= '0;
            read_data_req <= (num_q != 16'd0);
            state_q       <= StSendData;
          end
        end
        StSendData: begin
          eth_tx_en   <= 1'b1;
          eth_tx_data <= data_nib;
          crc_en      <= 1'b1;
          cnt_q       <= cnt_q + CntW'(1);
          if (cnt_q[2:0] == 3'd7 && more_words) read_data_req <= 1'b1;
          if (cnt_q == data_nibs - CntW'(1)) begin
            cnt_q   <= '0;
            state_q <= StSendCrc;
          end
        end
        StSendCrc: begin
          crc_en <= 1'b0;
          if (!cnt_q[3]) begin
            eth_tx_en   <= 1'b1;
            eth_tx_data <= fcs_nib;
            cnt_q       <= cnt_q + CntW'(1);
          end else begin
            eth_tx_en   <= 1'b0;
            eth_tx_data <= '0;
            send_end    <= 1'b1;
            crc_clr     <= 1'b1;
            id_q        <= id_q + 16'd1;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_my_ip_send.sv
// Scoreboard bench for my_ip_send with a behavioural nibble CRC32 in place of crc32_d4.
module tb_my_ip_send;

  localparam logic [47:0] T_BOARD_MAC = 48'h12_34_56_78_9A_BC;
  localparam logic [47:0] T_DES_MAC   = 48'h1C_2B_3A_49_58_67;
  localparam logic [31:0] T_BOARD_IP  = 32'hA9FE_0117;
  localparam logic [31:0] T_DES_IP    = 32'hA9FE_BF1F;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        send_en;
  logic [31:0] send_data;
  logic [15:0] send_data_num;
  logic [31:0] crc_data;
  logic [3:0]  crc_next;
  logic        send_end, read_data_req, eth_tx_en, crc_en, crc_clr;
  logic [3:0]  eth_tx_data;

  always #5 sys_clk = ~sys_clk;

  my_ip_send u_dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .send_en      (send_en),
    .send_data    (send_data),
    .send_data_num(send_data_num),
    .crc_data     (crc_data),
    .crc_next     (crc_next),
    .send_end     (send_end),
    .read_data_req(read_data_req),
    .eth_tx_en    (eth_tx_en),
    .eth_tx_data  (eth_tx_data),
    .crc_en       (crc_en),
    .crc_clr      (crc_clr)
  );

  // First wire bit enters the register first; register is MSB-first, init all ones.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r[31] ^ d[i]) ? ({r[30:0], 1'b0} ^ 32'h04C1_1DB7) : {r[30:0], 1'b0};
    end
    return r;
  endfunction

  logic [31:0] crc_nx;
  assign crc_nx   = crc_step(crc_data, eth_tx_data);
  assign crc_next = crc_nx[31:28];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   crc_data <= '1;
    else if (crc_clr) crc_data <= '1;
    else if (crc_en)  crc_data <= crc_nx;
  end

  int          n_cmp = 0, n_err = 0;
  int          en_cnt, req_cnt, end_cnt, clr_cnt, idle_bad, crce_bad;
  int          nib_idx, exp_nibs, exp_reqs, rx_bi;
  logic        prev_en;
  logic [3:0]  lo_nib;
  logic [7:0]  rx_b;
  logic [31:0] rx_crc;
  logic [7:0]  rx_bytes [256];
  logic [7:0]  exp_q [$];
  logic [7:0]  frm [$];
  logic [31:0] word_q [$];
  logic [15:0] exp_id;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: supplies words on request and scores every received byte.
  initial begin
    send_data = '0;
    prev_en   = 1'b0;
    nib_idx   = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        prev_en = 1'b0;
      end else begin
        if (read_data_req) begin
          req_cnt++;
          send_data = (word_q.size() > 0) ? word_q.pop_front() : 32'hEEEE_EEEE;
        end
        if (send_end) end_cnt++;
        if (crc_clr)  clr_cnt++;
        if (!eth_tx_en && eth_tx_data != 4'h0) idle_bad++;
        if (eth_tx_en && !prev_en) begin
          nib_idx = 0;
          rx_crc  = '1;
        end
        if (crc_en != (eth_tx_en && nib_idx >= 16 && nib_idx < exp_nibs - 8)) crce_bad++;
        if (eth_tx_en) begin
          en_cnt++;
          if (!nib_idx[0]) begin
            lo_nib = eth_tx_data;
          end else begin
            rx_b  = {eth_tx_data, lo_nib};
            rx_bi = nib_idx / 2;
            if (rx_bi < 256) rx_bytes[rx_bi] = rx_b;
            if (rx_bi >= 8) rx_crc = crc_step(crc_step(rx_crc, lo_nib), eth_tx_data);
            if (exp_q.size() > 0) check_val($sformatf("byte%0d", rx_bi), rx_b, exp_q.pop_front());
          end
          nib_idx++;
        end
        prev_en = eth_tx_en;
      end
    end
  end

  task automatic push_be(input logic [47:0] v, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic start_frame(input int n, input logic [31:0] seed);
    int          nw, hdr_at;
    logic [31:0] sum, wd;
    logic [15:0] cs;
    nw = (n + 3) / 4;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    push_be(T_DES_MAC, 6);
    push_be(T_BOARD_MAC, 6);
    push_be(48'h0800, 2);
    hdr_at = frm.size();
    push_be(48'h4500, 2);
    push_be(48'(28 + n), 2);
    push_be(48'(exp_id), 2);
    push_be(48'h4000, 2);
    push_be(48'h4011, 2);
    push_be(48'h0, 2);
    push_be(48'(T_BOARD_IP), 4);
    push_be(48'(T_DES_IP), 4);
    sum = '0;
    for (int i = 0; i < 10; i++) sum += {16'h0, frm[hdr_at + 2*i], frm[hdr_at + 2*i + 1]};
    while (sum[31:16] != 16'h0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    cs = ~sum[15:0];
    frm[hdr_at + 10] = cs[15:8];
    frm[hdr_at + 11] = cs[7:0];
    push_be(48'd1234, 2);
    push_be(48'd1234, 2);
    push_be(48'(8 + n), 2);
    push_be(48'h0, 2);
    for (int w = 0; w < nw; w++) begin
      wd = seed + 32'(w) * 32'h0102_0305;
      word_q.push_back(wd);
      for (int j = 0; j < 4; j++) if (4*w + j < n) frm.push_back(wd[31 - 8*j -: 8]);
    end
    for (int k = n; k < 18; k++) frm.push_back(8'h00);
    foreach (frm[i]) exp_q.push_back(frm[i]);
    exp_nibs = 2 * (frm.size() + 4);
    exp_reqs = nw;
    exp_id++;
    en_cnt = 0; req_cnt = 0; end_cnt = 0; clr_cnt = 0; idle_bad = 0; crce_bad = 0;
    @(negedge sys_clk);
    send_en       = 1'b1;
    send_data_num = 16'(n);
    @(negedge sys_clk);
    send_en       = 1'b0;
    send_data_num = 16'hFFFF;
  endtask

  task automatic finish_frame();
    int t;
    t = 0;
    while (end_cnt == 0 && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    repeat (3) @(negedge sys_clk);
    check_val("tx_en_cycles", en_cnt, exp_nibs);
    check_val("req_pulses", req_cnt, exp_reqs);
    check_val("send_end_pulses", end_cnt, 1);
    check_val("crc_clr_pulses", clr_cnt, 1);
    check_val("fcs_residue", rx_crc, 32'hC704_DD7B);
    check_val("sb_left", exp_q.size(), 0);
    check_val("idle_data_nonzero", idle_bad, 0);
    check_val("crc_en_window", crce_bad, 0);
    check_val("tx_en_after", eth_tx_en, 0);
  endtask

  task automatic run_frame(input int n, input logic [31:0] seed, input bit poke);
    int t;
    start_frame(n, seed);
    if (poke) begin
      t = 0;
      while (req_cnt == 0 && t < 2000) begin
        @(negedge sys_clk);
        t++;
      end
      check_val("poke_reached_data", 32'(req_cnt > 0), 1);
      send_en = 1'b1;
      @(negedge sys_clk);
      send_en = 1'b0;
    end
    finish_frame();
  endtask

  initial begin
    int t;
    sys_rst_n     = 1'b0;
    send_en       = 1'b0;
    send_data_num = '0;
    exp_id        = '0;
    exp_nibs      = 0;
    repeat (3) @(negedge sys_clk);
    check_val("reset_outputs",
              {26'h0, send_end, read_data_req, eth_tx_en, eth_tx_data != 4'h0, crc_en, crc_clr}, 0);
    sys_rst_n = 1'b1;

    run_frame(3, 32'hA1B2_C3D4, 1'b0);
    check_val("ip_checksum", {16'h0, rx_bytes[32], rx_bytes[33]}, 32'h269B);
    check_val("ip_total_len", {16'h0, rx_bytes[24], rx_bytes[25]}, 32'h001F);
    check_val("udp_len", {16'h0, rx_bytes[46], rx_bytes[47]}, 32'h000B);
    check_val("payload_b0", rx_bytes[50], 32'hA1);

    run_frame(4, 32'h0F1E_2D3C, 1'b0);
    check_val("second_id", {16'h0, rx_bytes[26], rx_bytes[27]}, 32'h0001);
    run_frame(5, 32'h1122_3344, 1'b0);
    run_frame(20, 32'h8899_AABB, 1'b0);
    run_frame(0, 32'h0, 1'b0);
    run_frame(3, 32'h5A6B_7C8D, 1'b1);
    en_cnt = 0;
    repeat (60) @(negedge sys_clk);
    check_val("no_restart", en_cnt, 0);

    // Abort a frame mid-payload, then expect a clean frame with ID 0.
    start_frame(20, 32'hCAFE_F00D);
    t = 0;
    while (req_cnt < 2 && t < 2000) begin
      @(negedge sys_clk);
      t++;
    end
    check_val("reached_send_data", 32'(req_cnt >= 2), 1);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 check_val("reset_mid_outputs",
                 {26'h0, send_end, read_data_req, eth_tx_en, eth_tx_data != 4'h0, crc_en, crc_clr},
                 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    exp_q.delete();
    word_q.delete();
    exp_id = '0;
    run_frame(3, 32'hA1B2_C3D4, 1'b0);
    check_val("id_after_reset", {16'h0, rx_bytes[26], rx_bytes[27]}, 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
